// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_pkg
//  Description : Shared op codes, FSM state encodings and operand-signedness
//                helpers for the iterative multiply/divide unit.
//  Contents    : MD_* funct3 op codes, MD_IDLE/MD_CALC/MD_DONE encodings,
//                REG_WIDTH (default XLEN), md_op1_signed/md_op2_signed.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_muldiv_pkg;

  typedef logic [2:0] md_op_t;
  typedef logic [1:0] md_state_t;

  // Default datapath width for the unit.
  localparam int REG_WIDTH = 64;

  // funct3 op codes.
  localparam md_op_t MD_MUL    = 3'd0;
  localparam md_op_t MD_MULH   = 3'd1;
  localparam md_op_t MD_MULHSU = 3'd2;
  localparam md_op_t MD_MULHU  = 3'd3;
  localparam md_op_t MD_DIV    = 3'd4;
  localparam md_op_t MD_DIVU   = 3'd5;
  localparam md_op_t MD_REM    = 3'd6;
  localparam md_op_t MD_REMU   = 3'd7;

  // FSM state encodings.
  localparam md_state_t MD_IDLE = 2'd0;
  localparam md_state_t MD_CALC = 2'd1;
  localparam md_state_t MD_DONE = 2'd2;

  // rs1 is signed for everything except the fully-unsigned ops.
  function automatic logic md_op1_signed(input md_op_t op);
    return (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU treats it as unsigned).
  function automatic logic md_op2_signed(input md_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_if
//  Description : Request/response bundle of the multiply/divide unit.
//  Signals     : in_valid/in_ready/op/word/op1_in/op2_in  request side
//                flush                                     abort
//                out_valid/out_ready/alu_out                response side
//                busy                                      CALC or DONE
//  Modports    : master (EXU / stimulus side), slave (alu_muldiv)
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] op1_in;
  logic [XLEN-1:0] op2_in;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  modport master (
    output in_valid, op, word, op1_in, op2_in, flush, out_ready,
    input  in_ready, out_valid, alu_out, busy
  );

  modport slave (
    input  in_valid, op, word, op1_in, op2_in, flush, out_ready,
    output in_ready, out_valid, alu_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_md_divider.sv
`default_nettype none
// ============================================================================
//  Module      : md_divider
//  Description : One restoring shift-subtract step of an unsigned divider.
//                The dividend register shifts left, feeding its MSB into the
//                partial remainder and taking the new quotient bit in its LSB.
//  Ports       : i_rem   partial remainder (always < i_dvsr)
//                i_dvnd  dividend / quotient shift register
//                i_dvsr  divisor magnitude
//                o_rem   next partial remainder
//                o_dvnd  next dividend / quotient shift register
//  Revision    : 1.0 - initial release
// ============================================================================
module md_divider #(
  parameter int XLEN = 64
) (
  input  wire logic [XLEN-1:0] i_rem,
  input  wire logic [XLEN-1:0] i_dvnd,
  input  wire logic [XLEN-1:0] i_dvsr,
  output logic      [XLEN-1:0] o_rem,
  output logic      [XLEN-1:0] o_dvnd
);
  logic [XLEN:0] w_trial;
  logic [XLEN:0] w_diff;
  logic          w_borrow;

  assign w_trial = {i_rem, i_dvnd[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, i_dvsr};
  // Since i_rem < i_dvsr, the trial fits below 2*i_dvsr, so the top bit of
  // the difference is set exactly when the subtraction went negative.
  assign w_borrow = w_diff[XLEN];

  assign o_rem  = w_borrow ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];
  assign o_dvnd = {i_dvnd[XLEN-2:0], ~w_borrow};
endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative RV M-extension unit: radix-2 shift-add multiplier
//                and restoring divider, one bit per clock, with valid/ready on
//                both sides and a synchronous flush. Optional 32-bit word ops.
//  Ports       : clk    clock
//                rst_n  asynchronous active-low reset
//                bus    alu_muldiv_if.slave (request, response, flush, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int XLEN     = REG_WIDTH,
  parameter bit HAS_WORD = 1'b1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_muldiv_if.slave bus
);
  localparam int            c_cnt_w   = $clog2(XLEN + 1);
  localparam logic [c_cnt_w-1:0] c_n_full  = c_cnt_w'(XLEN);
  localparam logic [c_cnt_w-1:0] c_n_word  = c_cnt_w'(32);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_0   = '0;

  // Low 32 bits extended to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] f_ext32(input logic [31:0] v, input logic sgn);
    return sgn ? XLEN'($signed(v)) : XLEN'(v);
  endfunction

  // ---------------------------------------------------------------- state
  md_state_t              r_state;
  logic [c_cnt_w-1:0]     r_cnt;
  md_op_t                 r_op;
  logic                   r_word;
  logic                   r_neg;     // result must be negated at the end
  logic                   r_fast;    // result already known at accept
  logic [XLEN-1:0]        r_dvsr;    // multiplicand / divisor magnitude
  logic [XLEN-1:0]        r_shift;   // multiplier / dividend->quotient
  logic [2*XLEN-1:0]      r_acc;     // product, or partial remainder in low half
  logic [XLEN-1:0]        r_result;

  // ------------------------------------------------ accept-side operand prep
  logic            w_word;
  logic            w_sgn1, w_sgn2;
  logic [XLEN-1:0] w_a, w_b;
  logic            w_neg1, w_neg2;
  logic [XLEN-1:0] w_m1, w_m2;
  logic [XLEN-1:0] w_min;
  logic            w_div_zero, w_ovf, w_illegal, w_fast;
  logic [XLEN-1:0] w_fast_raw, w_fast_res;

  assign w_word = HAS_WORD ? bus.word : 1'b0;
  assign w_sgn1 = md_op1_signed(bus.op);
  assign w_sgn2 = md_op2_signed(bus.op);

  // Operands are brought to width N first, then represented at XLEN.
  assign w_a    = w_word ? f_ext32(bus.op1_in[31:0], w_sgn1) : bus.op1_in;
  assign w_b    = w_word ? f_ext32(bus.op2_in[31:0], w_sgn2) : bus.op2_in;
  assign w_neg1 = w_sgn1 & w_a[XLEN-1];
  assign w_neg2 = w_sgn2 & w_b[XLEN-1];
  assign w_m1   = w_neg1 ? -w_a : w_a;
  assign w_m2   = w_neg2 ? -w_b : w_b;

  assign w_min      = w_word ? f_ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_div_zero = bus.op[2] & (w_b == '0);
  assign w_ovf      = bus.op[2] & ~bus.op[0] & (w_a == w_min) & (&w_b);
  assign w_illegal  = w_word & ~bus.op[2] & (bus.op[1:0] != 2'b00);
  assign w_fast     = w_illegal | w_div_zero | w_ovf;

  always_comb begin
    w_fast_raw = '0;
    if (w_illegal)
      w_fast_raw = '0;
    else if (w_div_zero)
      w_fast_raw = bus.op[1] ? w_a : '1;   // rem = dividend, quot = all ones
    else
      w_fast_raw = bus.op[1] ? '0 : w_a;   // overflow: rem = 0, quot = dividend
  end
  assign w_fast_res = w_word ? f_ext32(w_fast_raw[31:0], 1'b1) : w_fast_raw;

  // ------------------------------------------------------- iteration step
  logic [2*XLEN-1:0] w_mul_acc;
  logic [XLEN-1:0]   w_div_rem, w_div_dvnd;

  // Multiplier is scanned MSB first; word ops preload it left-aligned so
  // 32 steps consume exactly its 32 significant bits.
  assign w_mul_acc = {r_acc[2*XLEN-2:0], 1'b0}
                   + {{XLEN{1'b0}}, (r_shift[XLEN-1] ? r_dvsr : {XLEN{1'b0}})};

  md_divider #(
    .XLEN (XLEN)
  ) u_div (
    .i_rem  (r_acc[XLEN-1:0]),
    .i_dvnd (r_shift),
    .i_dvsr (r_dvsr),
    .o_rem  (w_div_rem),
    .o_dvnd (w_div_dvnd)
  );

  // ------------------------------------------------------ final sign fix
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem, w_raw, w_final;

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quot = r_neg ? -r_shift : r_shift;
    w_rem  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_raw  = '0;
    if (!r_op[2])
      w_raw = (r_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else
      w_raw = r_op[1] ? w_rem : w_quot;
    w_final = r_word ? f_ext32(w_raw[31:0], 1'b1) : w_raw;
  end

  // ------------------------------------------------------------ sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_neg    <= 1'b0;
      r_fast   <= 1'b0;
      r_dvsr   <= '0;
      r_shift  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_state <= MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (bus.in_valid) begin
            r_op    <= bus.op;
            r_word  <= w_word;
            r_neg   <= (bus.op[2] & bus.op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
            r_dvsr  <= w_m2;
            r_shift <= w_word ? (w_m1 << (XLEN - 32)) : w_m1;
            r_acc   <= '0;
            r_fast  <= w_fast;
            // The fast path parks in CALC for a single cycle with an empty
            // counter so its result appears one edge after accept.
            r_state <= MD_CALC;
            if (w_fast) begin
              r_cnt    <= c_cnt_0;
              r_result <= w_fast_res;
            end else begin
              r_cnt <= w_word ? c_n_word : c_n_full;
            end
          end
        end
        MD_CALC: begin
          if (r_cnt != c_cnt_0) begin
            r_cnt <= r_cnt - c_cnt_one;
            if (!r_op[2]) begin
              r_acc   <= w_mul_acc;
              r_shift <= r_shift << 1;
            end else begin
              r_acc   <= {{XLEN{1'b0}}, w_div_rem};
              r_shift <= w_div_dvnd;
            end
          end else begin
            if (!r_fast)
              r_result <= w_final;
            r_state <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (bus.out_ready)
            r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == MD_IDLE) && !bus.flush;
  assign bus.out_valid = (r_state == MD_DONE);
  assign bus.busy      = (r_state != MD_IDLE);
  assign bus.alu_out   = r_result;
endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Self-checking bench for alu_muldiv (XLEN=64, word ops on).
//                Directed table of corner vectors, backpressure, flush and
//                asynchronous-reset sequences, then random operations checked
//                against a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_muldiv_if #(.XLEN(64)) bus ();

  alu_muldiv #(
    .XLEN     (64),
    .HAS_WORD (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from the ISA rules, using wide/signed arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb;
    logic [31:0]        a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    sa = a; sb = b;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r32 = '0;
    if (!w) begin
      case (op)
        3'd0: return a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};        return p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};              return p[127:64]; end
        3'd4: begin
          if (b == 64'd0) return '1;
          if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
          return sa / sb;
        end
        3'd5: begin if (b == 64'd0) return '1; return a / b; end
        3'd6: begin
          if (b == 64'd0) return a;
          if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
          return sa % sb;
        end
        default: begin if (b == 64'd0) return a; return a % b; end
      endcase
    end
    case (op)
      3'd0: r32 = a32 * b32;
      3'd1, 3'd2, 3'd3: return 64'd0;
      3'd4: begin
        if (b32 == 32'd0) r32 = '1;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
        else r32 = sa32 / sb32;
      end
      3'd5: begin if (b32 == 32'd0) r32 = '1; else r32 = a32 / b32; end
      3'd6: begin
        if (b32 == 32'd0) r32 = a32;
        else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 32'd0;
        else r32 = sa32 % sb32;
      end
      default: begin if (b32 == 32'd0) r32 = a32; else r32 = a32 % b32; end
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  // Edges from accept to out_valid: 1 for the special cases, else N+1.
  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic bz, ovf;
    if (w && op >= 3'd1 && op <= 3'd3) return 1;
    bz  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
            : (a == 64'h8000_0000_0000_0000 && b == '1);
    if (op[2] && bz) return 1;
    if ((op == 3'd4 || op == 3'd6) && ovf) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_val();
    logic [31:0] hi, lo;
    hi = $urandom; lo = $urandom;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(1, 1000));
      4: return {hi, 32'h8000_0000};
      5: return {hi, 32'hFFFF_FFFF};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input int hold, input string name);
    int          lat;
    logic [63:0] held;
    logic        stable;
    @(negedge clk);
    bus.op = op; bus.word = w; bus.op1_in = a; bus.op2_in = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    check({name, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble the request lines: the unit must have captured them.
    bus.in_valid = 1'b0; bus.op = ~op; bus.word = ~w;
    bus.op1_in = {$urandom, $urandom}; bus.op2_in = {$urandom, $urandom};
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, ".latency"}, 64'(lat), 64'(exp_lat));
    check({name, ".alu_out"}, bus.alu_out, exp);
    if (hold > 0) begin
      held = bus.alu_out;
      stable = 1'b1;
      bus.in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!bus.out_valid || bus.alu_out !== held || bus.in_ready) stable = 1'b0;
      end
      check({name, ".hold_stable"}, 64'(stable), 64'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, ".release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;
    logic        seen;

    n_vec = 0;
    n_err = 0;
    //           op    w     a                        b                        expected                 lat
    tbl[0]  = '{3'd0, 1'b0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    tbl[1]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[2]  = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   65};
    tbl[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[4]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 65};
    tbl[5]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65};
    tbl[6]  = '{3'd5, 1'b0, 64'd100,                 64'd7,                   64'd14,                  65};
    tbl[7]  = '{3'd7, 1'b0, 64'd100,                 64'd7,                   64'd2,                   65};
    tbl[8]  = '{3'd5, 1'b0, 64'd5,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[9]  = '{3'd6, 1'b0, 64'd5,                   64'd0,                   64'd5,                   1};
    tbl[10] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    tbl[11] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1};
    tbl[12] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFE, 33};
    tbl[13] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[14] = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[15] = '{3'd1, 1'b1, 64'd12,                  64'd34,                  64'd0,                   1};
    tbl[16] = '{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[17] = '{3'd7, 1'b1, 64'h0000_0000_9000_0000, 64'h0000_0000_A000_0000, 64'hFFFF_FFFF_9000_0000, 33};
    tbl[18] = '{3'd7, 1'b1, 64'hABCD_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 64'd5,                   1};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.word = 1'b0;
    bus.op1_in = '0; bus.op2_in = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check("reset.alu_out", bus.alu_out, 64'd0);
    check("reset.busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 19; i++)
      run_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, 0,
             $sformatf("tbl%0d", i));

    // Backpressure: result held for 5 cycles with out_ready low.
    run_op(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 5, "backpressure");

    // Flush in the middle of a divide, with a competing request.
    @(negedge clk);
    bus.op = 3'd5; bus.word = 1'b0; bus.op1_in = 64'd1000; bus.op2_in = 64'd3;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush.busy_before", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.op1_in = 64'd3; bus.op2_in = 64'd4;
    #1;
    check("flush.in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush.idle", {62'd0, bus.busy, bus.out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    check("flush.no_result", 64'(seen), 64'd0);
    run_op(3'd5, 1'b0, 64'd1000, 64'd3, 64'd333, 65, 0, "after_flush");

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    bus.op = 3'd0; bus.word = 1'b0; bus.op1_in = 64'd123; bus.op2_in = 64'd456;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("arst.busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst.outputs", {bus.alu_out[61:0], bus.out_valid, bus.busy}, 64'd0);
    check("arst.alu_out", bus.alu_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    check("arst.no_result", 64'(seen), 64'd0);
    check("arst.in_ready", 64'(bus.in_ready), 64'd1);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = 1'($urandom_range(0, 1));
      ra  = pick_val();
      rb  = pick_val();
      run_op(rop, rw, ra, rb, ref_model(rop, rw, ra, rb), ref_lat(rop, rw, ra, rb), 0,
             $sformatf("rnd%0d op%0d w%0d a=%h b=%h", i, rop, rw, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
